// File: rtl/ddr3_ui_pkg.sv
// Shared encodings, FSM states and address helpers for the DDR3 user-interface model.
package ddr3_ui_pkg;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    typedef enum logic [2:0] {
        ST_CALIB,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_REFRESH
    } state_t;

    // Number of address bits consumed by one DATA_W word (addresses count 16-bit units).
    function automatic int unsigned addr_shift(input int unsigned data_w);
        return $clog2(data_w / 16);
    endfunction

endpackage

// File: rtl/ddr3_ui_if.sv
// Arbiter-facing user interface of the DDR3 controller model.
interface ddr3_ui_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 28
) ();

    logic [2:0]          cmd;
    logic                cmd_en;
    logic [ADDR_W-1:0]   addr;
    logic [5:0]          app_burst_number;
    logic                cmd_ready;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_data_en;
    logic                wr_data_end;
    logic [DATA_W/8-1:0] wr_data_mask;
    logic                wr_data_rdy;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_data_valid;
    logic                rd_data_end;
    logic                ref_req;
    logic                ref_ack;
    logic                init_calib_complete;
    logic                proto_err;

    modport master (
        output cmd, cmd_en, addr, app_burst_number,
        output wr_data, wr_data_en, wr_data_end, wr_data_mask,
        output ref_req,
        input  cmd_ready, wr_data_rdy, rd_data, rd_data_valid, rd_data_end,
        input  ref_ack, init_calib_complete, proto_err
    );

    modport slave (
        input  cmd, cmd_en, addr, app_burst_number,
        input  wr_data, wr_data_en, wr_data_end, wr_data_mask,
        input  ref_req,
        output cmd_ready, wr_data_rdy, rd_data, rd_data_valid, rd_data_end,
        output ref_ack, init_calib_complete, proto_err
    );

endinterface

// File: rtl/ddr3_rd_pipe.sv
// Fixed-latency read return pipeline: RD_LAT stages of {valid, end, data}.
module ddr3_rd_pipe #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_end,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_end,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] end_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            end_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            end_q[0] <= in_end;
            dat_q[0] <= in_data;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                end_q[i] <= end_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_end   = end_q[RD_LAT-1];
    assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/ddr3_ui_model.sv
// Behavioural DDR3 user-interface model: calibration delay, bursts with byte masks,
// fixed-latency reads, refresh handshake and a sticky protocol-error flag.
module ddr3_ui_model
    import ddr3_ui_pkg::*;
#(
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned ADDR_W       = 28,
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned CALIB_CYCLES = 256,
    parameter int unsigned RD_LAT       = 4,
    parameter int unsigned REF_CYCLES   = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    ddr3_ui_if.slave ui
);

    localparam int unsigned SHIFT   = addr_shift(DATA_W);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned CNT_MAX = (CALIB_CYCLES > REF_CYCLES) ? CALIB_CYCLES : REF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REF_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [5:0]            beat_q, beat_d;
    logic [5:0]            len_m1_q, len_m1_d;
    logic                  ref_pend_q, ref_pend_d;
    logic                  calib_q, calib_d;
    logic                  err_q, err_d;

    logic                  cmd_ready_c;
    logic                  last_beat_c;
    logic                  wr_beat_c;
    logic                  rd_issue_c;
    logic [DEPTH_LOG2-1:0] start_idx_c;

    logic [DATA_W-1:0]     mem [DEPTH];

    assign start_idx_c = DEPTH_LOG2'(ui.addr >> SHIFT);
    assign last_beat_c = (beat_q == len_m1_q);
    assign cmd_ready_c = (state_q == ST_IDLE) && !ref_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CALIB;
            cnt_q      <= '0;
            idx_q      <= '0;
            beat_q     <= '0;
            len_m1_q   <= '0;
            ref_pend_q <= 1'b0;
            calib_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            len_m1_q   <= len_m1_d;
            ref_pend_q <= ref_pend_d;
            calib_q    <= calib_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        len_m1_d   = len_m1_q;
        ref_pend_d = ref_pend_q | ui.ref_req;
        calib_d    = calib_q;
        err_d      = err_q;
        wr_beat_c  = 1'b0;
        rd_issue_c = 1'b0;

        if (ui.cmd_en && !cmd_ready_c) begin
            err_d = 1'b1;
        end
        if (ui.wr_data_en && (state_q != ST_WRITE)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_CALIB: begin
                if (cnt_q == CALIB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    calib_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                // A refresh request, even one arriving this cycle, wins over a command.
                if (ref_pend_q || ui.ref_req) begin
                    state_d    = ST_REFRESH;
                    cnt_d      = '0;
                    ref_pend_d = 1'b0;
                end else if (ui.cmd_en) begin
                    if (ui.cmd == CMD_WR || ui.cmd == CMD_RD) begin
                        state_d  = (ui.cmd == CMD_WR) ? ST_WRITE : ST_READ;
                        idx_d    = start_idx_c;
                        beat_d   = '0;
                        len_m1_d = ui.app_burst_number;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (ui.wr_data_en) begin
                    wr_beat_c = 1'b1;
                    idx_d     = idx_q + DEPTH_LOG2'(1);
                    beat_d    = beat_q + 6'd1;
                    if (ui.wr_data_end != last_beat_c) begin
                        err_d = 1'b1;
                    end
                    if (last_beat_c) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                rd_issue_c = 1'b1;
                idx_d      = idx_q + DEPTH_LOG2'(1);
                beat_d     = beat_q + 6'd1;
                if (last_beat_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (cnt_q == REF_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_CALIB;
                cnt_d   = '0;
            end
        endcase
    end

    // Byte-masked write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_beat_c) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (!ui.wr_data_mask[b]) begin
                    mem[idx_q][b*8 +: 8] <= ui.wr_data[b*8 +: 8];
                end
            end
        end
    end

    ddr3_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_issue_c),
        .in_end    (rd_issue_c && last_beat_c),
        .in_data   (mem[idx_q]),
        .out_valid (ui.rd_data_valid),
        .out_end   (ui.rd_data_end),
        .out_data  (ui.rd_data)
    );

    assign ui.cmd_ready           = cmd_ready_c;
    assign ui.wr_data_rdy         = (state_q == ST_WRITE);
    assign ui.ref_ack             = (state_q == ST_REFRESH) && (cnt_q == REF_LAST);
    assign ui.init_calib_complete = calib_q;
    assign ui.proto_err           = err_q;

endmodule

// File: tb/tb_ddr3_ui_model.sv
// Scoreboard bench for ddr3_ui_model: reference memory model plus expected-read queue.
module tb_ddr3_ui_model;
    import ddr3_ui_pkg::*;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 28;
    localparam int          DEPTH  = 1024;
    localparam int          SHIFT  = 3;
    localparam int          CALIB  = 256;
    localparam int          RD_LAT = 4;
    localparam int          REF    = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              is_end;
        int                cyc;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    rd_exp_t           exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] beat_data [64];

    ddr3_ui_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ui ();

    ddr3_ui_model #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH_LOG2   (10),
        .CALIB_CYCLES (CALIB),
        .RD_LAT       (RD_LAT),
        .REF_CYCLES   (REF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ui    (ui)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read-return checker: every valid beat must match the head of the expected queue.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rst_n) begin
            if (ui.rd_data_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", DATA_W'(exp_q.size()), DATA_W'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", ui.rd_data, e.data);
                    check("rd_end", DATA_W'(ui.rd_data_end), DATA_W'(e.is_end));
                    check("rd_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
                end
            end else begin
                check("rd_end_stray", DATA_W'(ui.rd_data_end), DATA_W'(0));
            end
        end
    end

    task automatic idle_inputs();
        ui.cmd = 3'd0; ui.cmd_en = 1'b0; ui.addr = '0; ui.app_burst_number = 6'd0;
        ui.wr_data = '0; ui.wr_data_en = 1'b0; ui.wr_data_end = 1'b0; ui.wr_data_mask = '0;
        ui.ref_req = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ui.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ui.cmd_ready) check("cmd_ready_timeout", DATA_W'(ui.cmd_ready), DATA_W'(1));
    endtask

    task automatic wait_calib();
        int n = 0;
        while (!ui.init_calib_complete && n < CALIB + 50) begin
            @(negedge clk);
            n++;
        end
        check("calib_wait", DATA_W'(ui.init_calib_complete), DATA_W'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", DATA_W'(exp_q.size()), DATA_W'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [ADDR_W-1:0] a, input int bl, output int acc);
        wait_ready();
        ui.cmd = c; ui.cmd_en = 1'b1; ui.addr = a; ui.app_burst_number = 6'(bl - 1);
        acc = cyc;
        @(negedge clk);
        ui.cmd_en = 1'b0;
    endtask

    function automatic int word_of(input logic [ADDR_W-1:0] a);
        return int'(a[ADDR_W-1:SHIFT]) % DEPTH;
    endfunction

    task automatic write_beats(input int idx0, input int nb, input int bl, input logic [15:0] mask, input bit early_end);
        for (int k = 0; k < nb; k++) begin
            ui.wr_data      = beat_data[k];
            ui.wr_data_en   = 1'b1;
            ui.wr_data_mask = mask;
            ui.wr_data_end  = (k == bl - 1) || early_end;
            if (k == 0) check("wr_rdy", DATA_W'(ui.wr_data_rdy), DATA_W'(1));
            for (int b = 0; b < 16; b++) begin
                if (!mask[b]) model_mem[(idx0 + k) % DEPTH][b*8 +: 8] = beat_data[k][b*8 +: 8];
            end
            @(negedge clk);
        end
        ui.wr_data_en = 1'b0; ui.wr_data_end = 1'b0; ui.wr_data_mask = '0;
    endtask

    task automatic wr_burst(input logic [ADDR_W-1:0] a, input int bl, input logic [15:0] mask, input bit early_end);
        int acc;
        issue(CMD_WR, a, bl, acc);
        write_beats(word_of(a), bl, bl, mask, early_end);
    endtask

    task automatic rd_burst(input logic [ADDR_W-1:0] a, input int bl);
        int      acc;
        rd_exp_t e;
        issue(CMD_RD, a, bl, acc);
        for (int k = 0; k < bl; k++) begin
            e.data   = model_mem[(word_of(a) + k) % DEPTH];
            e.is_end = (k == bl - 1);
            e.cyc    = acc + 1 + k + RD_LAT;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        int bad;
        int c0;
        int n;
        int acks;
        int acc;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", DATA_W'(ui.cmd_ready), DATA_W'(0));
        check("rst_wr_rdy", DATA_W'(ui.wr_data_rdy), DATA_W'(0));
        check("rst_rd_valid", DATA_W'(ui.rd_data_valid), DATA_W'(0));
        check("rst_rd_data", ui.rd_data, DATA_W'(0));
        check("rst_ref_ack", DATA_W'(ui.ref_ack), DATA_W'(0));
        check("rst_calib", DATA_W'(ui.init_calib_complete), DATA_W'(0));
        check("rst_err", DATA_W'(ui.proto_err), DATA_W'(0));

        // Calibration: complete exactly CALIB edges after release
        rst_n = 1'b1;
        bad = 0;
        for (int k = 1; k <= CALIB; k++) begin
            @(negedge clk);
            if (k < CALIB && (ui.init_calib_complete || ui.cmd_ready)) bad++;
        end
        check("calib_early", DATA_W'(bad), DATA_W'(0));
        check("calib_done", DATA_W'(ui.init_calib_complete), DATA_W'(1));
        check("calib_ready", DATA_W'(ui.cmd_ready), DATA_W'(1));

        // Four-beat write then read at 0x40
        for (int k = 0; k < 4; k++) beat_data[k] = DATA_W'(8'h11 * (k + 1));
        wr_burst(28'h40, 4, 16'h0000, 1'b0);
        rd_burst(28'h40, 4);
        wait_drain();

        // Byte mask keeps old content
        beat_data[0] = '1;
        wr_burst(28'd40, 1, 16'h0000, 1'b0);
        beat_data[0] = '0;
        wr_burst(28'd40, 1, 16'hFFFE, 1'b0);
        rd_burst(28'd40, 1);
        wait_drain();

        // Wrap at the top of the array, then back-to-back reads
        beat_data[0] = {4{32'hA5A5_0001}};
        beat_data[1] = {4{32'hA5A5_0002}};
        beat_data[2] = {4{32'hA5A5_0003}};
        wr_burst(28'(1023 * 8), 3, 16'h0000, 1'b0);
        rd_burst(28'd0, 2);
        rd_burst(28'(1023 * 8), 3);
        wait_drain();

        // Refresh beats a same-cycle read command
        wait_ready();
        c0 = cyc;
        ui.cmd = CMD_RD; ui.addr = 28'h40; ui.app_burst_number = 6'd3;
        ui.cmd_en = 1'b1; ui.ref_req = 1'b1;
        @(negedge clk);
        ui.cmd_en = 1'b0; ui.ref_req = 1'b0;
        check("ref_blocks_cmd", DATA_W'(ui.cmd_ready), DATA_W'(0));
        n = 0;
        while (!ui.ref_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ref_ack_cycle", DATA_W'(cyc), DATA_W'(c0 + REF));
        @(negedge clk);
        check("ref_ack_pulse", DATA_W'(ui.ref_ack), DATA_W'(0));
        check("ref_ready_back", DATA_W'(ui.cmd_ready), DATA_W'(1));
        rd_burst(28'h40, 4);
        wait_drain();

        // Two requests during a long read merge into one refresh
        rd_burst(28'h40, 12);
        acks = 0;
        for (int k = 0; k < 40; k++) begin
            ui.ref_req = (k == 1 || k == 4);
            @(negedge clk);
            if (ui.ref_ack) acks++;
        end
        ui.ref_req = 1'b0;
        check("ref_merge", DATA_W'(acks), DATA_W'(1));
        wait_drain();
        check("no_err_clean", DATA_W'(ui.proto_err), DATA_W'(0));

        // Reset mid-burst keeps the beats already written
        for (int k = 0; k < 4; k++) beat_data[k] = {4{32'hC0DE_0000 + 32'(k)}};
        issue(CMD_WR, 28'(100 * 8), 4, acc);
        write_beats(100, 2, 4, 16'h0000, 1'b0);
        do_reset();
        check("abort_no_rdy", DATA_W'(ui.wr_data_rdy), DATA_W'(0));
        wait_calib();
        rd_burst(28'(100 * 8), 2);
        wait_drain();
        check("abort_no_err", DATA_W'(ui.proto_err), DATA_W'(0));

        // Protocol errors: command during calibration
        do_reset();
        repeat (5) @(negedge clk);
        ui.cmd_en = 1'b1;
        @(negedge clk);
        ui.cmd_en = 1'b0;
        check("err_calib_cmd", DATA_W'(ui.proto_err), DATA_W'(1));
        wait_calib();
        check("err_sticky", DATA_W'(ui.proto_err), DATA_W'(1));

        // Illegal command code
        do_reset();
        check("err_rst_clear", DATA_W'(ui.proto_err), DATA_W'(0));
        wait_calib();
        wait_ready();
        ui.cmd = 3'd5; ui.cmd_en = 1'b1;
        @(negedge clk);
        ui.cmd_en = 1'b0;
        check("err_illegal", DATA_W'(ui.proto_err), DATA_W'(1));
        check("illegal_stays_idle", DATA_W'(ui.cmd_ready), DATA_W'(1));
        check("illegal_no_write", DATA_W'(ui.wr_data_rdy), DATA_W'(0));

        // Early end marker: data still lands, flag sticks
        do_reset();
        wait_calib();
        check("err_clear2", DATA_W'(ui.proto_err), DATA_W'(0));
        beat_data[0] = {4{32'h0BAD_0001}};
        beat_data[1] = {4{32'h0BAD_0002}};
        wr_burst(28'(200 * 8), 2, 16'h0000, 1'b1);
        check("err_early_end", DATA_W'(ui.proto_err), DATA_W'(1));
        rd_burst(28'(200 * 8), 2);
        wait_drain();
        check("err_sticky2", DATA_W'(ui.proto_err), DATA_W'(1));

        // Write data outside a write burst
        do_reset();
        wait_calib();
        ui.wr_data_en = 1'b1;
        @(negedge clk);
        ui.wr_data_en = 1'b0;
        check("err_stray_wr", DATA_W'(ui.proto_err), DATA_W'(1));

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ddr3_ui_model.md
# ddr3_ui_model

Parametrised, single-clock behavioural model of the DDR3 controller user interface, replacing the fixed 128×128-bit stub in simulation and lint builds. It sits between the memory arbiter and the pin-level DDR3 port (pins not modelled here). It adds:
- calibration delay
- real command handshake and multi-beat bursts with byte-preserving masks
- fixed-latency read pipeline with end markers
- refresh request/acknowledge
- sticky protocol-error flag for the bench

## Interface
- DATA_W, 128: user data width; multiple of 16.
- ADDR_W, 28: user address width, in 16-bit DDR units.
- DEPTH_LOG2, 10: log2 of modelled words (DATA_W bits each).
- CALIB_CYCLES, 256: cycles from reset release to `init_calib_complete`; at least 1.
- RD_LAT, 4: cycles from read-beat issue to `rd_data_valid`; at least 1.
- REF_CYCLES, 8: busy cycles per refresh; at least 1.

Ports:
- clk  in  1  sole clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd  in  3  command: 3'd0 write, 3'd1 read; all other codes are illegal.
- cmd_en  in  1  command strobe.
- addr  in  ADDR_W  start address.
- app_burst_number  in  6  burst length minus 1 (1..64 beats).
- cmd_ready  out  1  command accepted when `cmd_en && cmd_ready`.
- wr_data  in  DATA_W  write beat.
- wr_data_en  in  1  write beat strobe.
- wr_data_end  in  1  marks the last write beat.
- wr_data_mask  in  DATA_W/8  1 = byte not written (old content kept).
- wr_data_rdy  out  1  model accepts write beats.
- rd_data  out  DATA_W  read beat.
- rd_data_valid  out  1  read beat valid.
- rd_data_end  out  1  last beat of a read burst.
- ref_req  in  1  refresh request pulse.
- ref_ack  out  1  one-cycle refresh-done pulse.
- init_calib_complete  out  1  model ready; sticky until reset.
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- Word index = `addr >> log2(DATA_W/16)`, taking the low DEPTH_LOG2 bits.
  - Beat k of a burst uses index + k, wrapping modulo 2^DEPTH_LOG2.
- Burst length `len = app_burst_number + 1`, captured at command accept.
- FSM states: CALIB, IDLE, WRITE, READ, REFRESH. Reset state is CALIB.
- CALIB: a counter runs for CALIB_CYCLES cycles, then the FSM goes to IDLE and `init_calib_complete` rises.
- IDLE: `cmd_ready = 1` iff no refresh is pending (combinational from state).
  - Pending refresh has priority over a same-cycle `cmd_en`: go to REFRESH, leave the command unaccepted.
  - Accepted write → WRITE. Accepted read → READ.
  - Illegal code while accepted: set `proto_err`, stay in IDLE.
- WRITE: `wr_data_rdy = 1`.
  - Each `wr_data_en` beat writes its unmasked bytes to the current index and increments the beat count.
  - After beat `len` → IDLE.
  - `wr_data_end` asserted on any beat other than the last, or absent on the last beat: set `proto_err`. Termination follows the beat count regardless.
- READ: issue one beat per cycle.
  - Each issue samples the memory word in that cycle into the read pipeline.
  - After `len` issues → IDLE. The pipeline drains independently, so a new command can be accepted while earlier read data is still emerging.
- REFRESH: hold for REF_CYCLES cycles, pulse `ref_ack` on the last cycle, then go to IDLE.
  - `ref_req` arriving in any state sets a pending flag, cleared on entry to REFRESH.
  - Multiple requests while pending merge into one refresh.
- `cmd_en` while `cmd_ready = 0` (including during CALIB): set `proto_err`, command ignored.
- `wr_data_en` outside WRITE: set `proto_err`, data ignored.
- Memory array is not reset; simulation initialises it to zero.

## Timing
- Every output resets to 0; the read pipeline and pending-refresh flag are cleared.
- Reset mid-burst aborts the burst. Beats already written remain in memory.
- Write beat accepted on the edge where `wr_data_en && wr_data_rdy`. The data is readable by a read issued one cycle later.
- Read beat issued in cycle t: `rd_data_valid` high in cycle t + RD_LAT. Beats are back-to-back, and `rd_data_end` coincides with the last valid beat.
- `ref_ack` is high for exactly one cycle; `cmd_ready` returns the following cycle.
- Command accepted at edge t: WRITE/READ is active from t+1, so `wr_data_rdy` rises at t+1.

## Structure
- Package `ddr3_ui_pkg` holds:
  - command encodings `CMD_WR`, `CMD_RD`
  - FSM state enum
  - helper function for the address-shift width
- Sub-module `ddr3_rd_pipe`: RD_LAT-deep shift register of {valid, end, data}, with asynchronous clear.

## Test plan
- Release reset with CALIB_CYCLES=256 → `init_calib_complete` rises exactly 256 cycles after reset release; `cmd_ready` stays 0 before that.
- Write 4 beats at addr 0x40 (data 0x11..0x44, mask 0), then read 4 beats → read data is 0x11..0x44 starting RD_LAT cycles after the first issue, and `rd_data_end` is asserted on the 4th beat only.
- Write 0xFF..FF to word 5, then write 0x00 to word 5 with `wr_data_mask = 16'hFFFE` → a read returns 0xFF..FF00.
- Burst of 3 beats starting at the last word (index 1023) → beats land at indices 1023, 0, 1.
- `ref_req` in the same cycle as `cmd_en` (read) in IDLE → REFRESH first, `ref_ack` pulses after 8 cycles, then the read is accepted.
- Drive `cmd_en` during CALIB, `cmd = 3'd5`, and an early `wr_data_end` → `proto_err` is set and stays set until reset.
